// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter
//   Converts debounced button levels into single key events for the calculator core.
//   Simultaneous presses resolve to the lowest set index; each event is held with a
//   valid/ack handshake. After the event is taken the block waits for full release,
//   then enforces a lockout gap before the next press is accepted.
//   Optional feature: define BTN_AUTO_REPEAT_EN to enable auto-repeat of a held key.

module btn_event_arbiter #(
    parameter int unsigned N_BTN        = 5,
    parameter int unsigned CODE_W       = 3,
    parameter int unsigned LOCKOUT_CYC  = 1000,
    parameter int unsigned REPEAT_DELAY = 5000,
    parameter int unsigned REPEAT_RATE  = 2000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BTN-1:0]  btn,
    input  logic              key_ack,
    output logic              key_valid,
    output logic [CODE_W-1:0] key_code,
    output logic              key_multi,
    output logic              key_rpt,
    output logic              busy
);

    // Shared counter sized for the longest interval it ever has to measure.
    localparam int unsigned MaxLd  = (LOCKOUT_CYC > REPEAT_DELAY) ? LOCKOUT_CYC : REPEAT_DELAY;
    localparam int unsigned MaxCyc = (MaxLd > REPEAT_RATE) ? MaxLd : REPEAT_RATE;
    localparam int unsigned CntW   = $clog2(MaxCyc + 1);

    localparam logic [CntW-1:0] CntMax   = {CntW{1'b1}};
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] LockLast = CntW'(LOCKOUT_CYC - 1);

`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CntW-1:0] DelayLast = CntW'(REPEAT_DELAY - 1);
    localparam logic [CntW-1:0] RateLast  = CntW'(REPEAT_RATE - 1);
`endif

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StHold,
        StLockout
    } state_e;

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [CntW-1:0]     cnt_inc;
    logic [CODE_W-1:0]   key_code_q, key_code_d;
    logic                key_multi_q, key_multi_d;
    logic [CODE_W-1:0]   low_idx;
    logic                multi_now;
    logic                any_btn;

`ifdef BTN_AUTO_REPEAT_EN
    logic                key_rpt_q, key_rpt_d;
    logic                cancel_q, cancel_d;
    logic                code_held;
    logic [CntW-1:0]     rpt_last;
`endif

    assign any_btn = |btn;

    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign multi_now = |(btn & (btn - N_BTN'(1)));

    // Saturating increment so the counter never wraps.
    assign cnt_inc = (cnt_q == CntMax) ? cnt_q : (cnt_q + CntOne);

    // Priority encoder: lowest set button index wins.
    always_comb begin
        low_idx = '0;
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (btn[i]) begin
                low_idx = CODE_W'(i);
            end
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    // Level of the button whose event was last issued.
    always_comb begin
        code_held = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            if (key_code_q == CODE_W'(i)) begin
                code_held = btn[i];
            end
        end
    end

    // First repeat waits the long delay, later ones the shorter rate.
    assign rpt_last = key_rpt_q ? RateLast : DelayLast;
`endif

    // Next-state logic for the handshake / release / lockout sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_multi_d = key_multi_q;
`ifdef BTN_AUTO_REPEAT_EN
        key_rpt_d   = key_rpt_q;
        cancel_d    = cancel_q;
`endif

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (any_btn) begin
                    state_d     = StIssue;
                    key_code_d  = low_idx;
                    key_multi_d = multi_now;
`ifdef BTN_AUTO_REPEAT_EN
                    key_rpt_d   = 1'b0;
`endif
                end
            end

            // Event is pending; inputs other than the ack are ignored.
            StIssue: begin
                if (key_ack) begin
                    state_d = StHold;
                    cnt_d   = '0;
`ifdef BTN_AUTO_REPEAT_EN
                    cancel_d = 1'b0;
`endif
                end
            end

            StHold: begin
                if (!any_btn) begin
                    state_d = StLockout;
                    cnt_d   = '0;
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (!code_held) begin
                        // Original key let go while another is held: no more repeats.
                        cancel_d = 1'b1;
                    end else if (!cancel_q && (cnt_q >= rpt_last)) begin
                        state_d     = StIssue;
                        cnt_d       = '0;
                        key_rpt_d   = 1'b1;
                        key_multi_d = multi_now;
                    end else begin
                        cnt_d = cnt_inc;
                    end
`else
                    cnt_d = cnt_q;
`endif
                end
            end

            // Any press during lockout restarts the gap from zero.
            StLockout: begin
                if (any_btn) begin
                    cnt_d = '0;
                end else if (cnt_q >= LockLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // State, counter and captured event registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            key_code_q  <= '0;
            key_multi_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_multi_q <= key_multi_d;
        end
    end

`ifdef BTN_AUTO_REPEAT_EN
    // Repeat flag and repeat-cancel latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_rpt_q <= 1'b0;
            cancel_q  <= 1'b0;
        end else begin
            key_rpt_q <= key_rpt_d;
            cancel_q  <= cancel_d;
        end
    end

    assign key_rpt = key_rpt_q;
`else
    assign key_rpt = 1'b0;
`endif

    // Outputs decode directly from registered state so reset clears them at once.
    assign key_valid = (state_q == StIssue);
    assign busy      = (state_q != StIdle);
    assign key_code  = key_code_q;
    assign key_multi = key_multi_q;

endmodule
